seq_divider: RTL

Multi-cycle restoring integer divider, the inverse companion of the core's ripple-carry adder datapath. It computes quotient and remainder by repeated trial subtraction, one bit per cycle. It is controlled by a start/busy/done handshake. It serves the M-extension DIV/DIVU/REM/REMU path next to the ALU, with RISC-V results for the special cases.

---
 rtl/div_pkg.sv | 14 +
 rtl/seq_divider_rca.sv | 22 ++
 rtl/seq_divider.sv | 133 +++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding and
// the iteration-counter sizing helper.
package div_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  // Counter must hold the value n itself, so it needs clog2(n+1) bits.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_divider_rca.sv
// Ripple-carry adder; the divider feeds it an inverted divisor with carry-in 1
// so that it acts as the trial subtractor.
module seq_divider_rca #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);

  always_comb begin
    logic carry;
    carry = cin;
    sum   = '0;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (one quotient bit per cycle) with RISC-V
// results for divide-by-zero and signed overflow.
module seq_divider
  import div_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_signed,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = cnt_width(N);
  localparam logic [N-1:0] ONE     = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  logic [1:0]    state_reg;
  logic [CW-1:0] count_reg;
  logic [N-1:0]  pr_reg;       // partial remainder; its extra top bit is always 0 after a restore
  logic [N-1:0]  wq_reg;       // working dividend shifting out, quotient shifting in
  logic [N-1:0]  dvs_reg;
  logic          sq_reg;
  logic          sr_reg;
  logic          dz_reg;
  logic          special_reg;

  logic          dvd_neg;
  logic          dvs_neg;
  logic [N-1:0]  abs_dvd;
  logic [N-1:0]  abs_dvs;
  logic          zero_div;
  logic          overflow;
  logic [N:0]    shifted;
  logic [N:0]    trial;
  logic          q_bit;

  assign dvd_neg  = is_signed & dividend[N-1];
  assign dvs_neg  = is_signed & divisor[N-1];
  assign abs_dvd  = dvd_neg ? (~dividend + ONE) : dividend;
  assign abs_dvs  = dvs_neg ? (~divisor + ONE) : divisor;
  assign zero_div = (divisor == '0);
  assign overflow = is_signed & (dividend == MIN_NEG) & (&divisor);

  assign shifted = {pr_reg, wq_reg[N-1]};

  seq_divider_rca #(
    .W(N + 1)
  ) u_trial_sub (
    .a  (shifted),
    .b  (~{1'b0, dvs_reg}),
    .cin(1'b1),
    .sum(trial)
  );

  assign q_bit = ~trial[N];
  assign busy  = (state_reg != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      count_reg   <= '0;
      pr_reg      <= '0;
      wq_reg      <= '0;
      dvs_reg     <= '0;
      sq_reg      <= 1'b0;
      sr_reg      <= 1'b0;
      dz_reg      <= 1'b0;
      special_reg <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg <= S_RUN;
            dvs_reg   <= abs_dvs;
            if (zero_div || overflow) begin
              // Short path: one idle RUN cycle (count = 1) with results preloaded
              // and sign fixes disabled, so done lands two edges after start.
              special_reg <= 1'b1;
              count_reg   <= CW'(1);
              sq_reg      <= 1'b0;
              sr_reg      <= 1'b0;
              dz_reg      <= zero_div;
              wq_reg      <= zero_div ? '1 : dividend;
              pr_reg      <= zero_div ? dividend : '0;
            end else begin
              special_reg <= 1'b0;
              count_reg   <= CW'(N);
              sq_reg      <= dvd_neg ^ dvs_neg;
              sr_reg      <= dvd_neg;
              dz_reg      <= 1'b0;
              wq_reg      <= abs_dvd;
              pr_reg      <= '0;
            end
          end
        end
        S_RUN: begin
          if (!special_reg) begin
            pr_reg <= q_bit ? trial[N-1:0] : shifted[N-1:0];
            wq_reg <= {wq_reg[N-2:0], q_bit};
          end
          count_reg <= count_reg - CW'(1);
          if (count_reg == CW'(1)) begin
            state_reg <= S_FIN;
          end
        end
        S_FIN: begin
          quotient    <= sq_reg ? (~wq_reg + ONE) : wq_reg;
          remainder   <= sr_reg ? (~pr_reg + ONE) : pr_reg;
          div_by_zero <= dz_reg;
          done        <= 1'b1;
          state_reg   <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule
